// File: rtl/bcd_game_pkg.sv
// Shared types, field widths and BCD helpers for the BCD math game.
// Holds the round-sequencer state enum, the BCD digit type, the widths of
// the operand, answer, count and timer fields, and the two-digit BCD
// increment used by the round and score counters.
package bcd_game_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int OPERAND_W = 16;  // 4 BCD digits
  localparam int ANSWER_W  = 20;  // 5 BCD digits
  localparam int COUNT_W   = 8;   // 2 BCD digits
  localparam int TIMER_W   = 32;  // holds any TIMEOUT_CYC up to 2^32

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_A = 3'd1,
    S_CAP_A   = 3'd2,
    S_FETCH_B = 3'd3,
    S_CAP_B   = 3'd4,
    S_PLAY    = 3'd5,
    S_JUDGE   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  // Two-digit BCD increment; the low digit wraps 9->0 and carries upward.
  function automatic logic [COUNT_W-1:0] bcd_inc2(input logic [COUNT_W-1:0] v);
    bcd_digit_t lo;
    bcd_digit_t hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo == 4'd9) begin
      lo = 4'd0;
      if (hi == 4'd9) begin
        hi = 4'd0;
      end else begin
        hi = hi + 4'd1;
      end
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  // Converts a small integer (0..99) to two BCD digits; used for parameters.
  function automatic logic [COUNT_W-1:0] to_bcd2(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

endpackage

// File: rtl/bcd_add4.sv
// Combinational 4-digit BCD adder.
// Ports:
//   a, b : 16-bit BCD operands {D1000,D100,D10,D1}
//   sum  : 20-bit BCD result; the top digit is the decimal carry-out (0 or 1)
// Each digit is added in binary and corrected by +6 when it exceeds 9.
module bcd_add4
  import bcd_game_pkg::*;
(
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  output logic [ANSWER_W-1:0]  sum
);

  // Ripple the decimal carry through the four digit positions.
  always_comb begin
    logic [4:0] digit_sum;
    logic       carry;
    digit_sum = 5'd0;
    carry     = 1'b0;
    sum       = {ANSWER_W{1'b0}};
    for (int i = 0; i < 4; i++) begin
      digit_sum = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, carry};
      // Max raw digit is 9+9+1 = 19; +6 keeps the low nibble in 0..9.
      if (digit_sum > 5'd9) begin
        digit_sum = digit_sum + 5'd6;
        carry     = 1'b1;
      end else begin
        carry     = 1'b0;
      end
      sum[i*4 +: 4] = digit_sum[3:0];
    end
    sum[19:16] = {3'd0, carry};
  end

endmodule

// File: rtl/bcd_round_sequencer.sv
// Round controller for the BCD math game.
// Draws two 4-digit BCD operands from the RNG per round, runs a per-round
// countdown, judges the player's 5-digit BCD answer and keeps round/score
// counts over a game of ROUNDS rounds.
// Ports:
//   clk, rst        : clock (rising edge) and asynchronous active-high reset
//   start, abort    : begin a game (IDLE/DONE only) / return to IDLE at once
//   rng_d           : RNG digits, valid the cycle after fetch_num
//   submit, answer  : answer strobe (PLAY only) and 5-digit BCD answer
//   fetch_num       : RNG capture strobe
//   op_a, op_b      : current BCD operands
//   round_bcd       : current round, 2-digit BCD
//   score_bcd       : correct answers, 2-digit BCD
//   busy/play/done  : state flags
//   correct/wrong/timeout : one-cycle verdict pulses in JUDGE
module bcd_round_sequencer
  import bcd_game_pkg::*;
#(
  parameter int ROUNDS      = 10,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [OPERAND_W-1:0] rng_d,
  input  logic                 submit,
  input  logic [ANSWER_W-1:0]  answer,
  output logic                 fetch_num,
  output logic [OPERAND_W-1:0] op_a,
  output logic [OPERAND_W-1:0] op_b,
  output logic [COUNT_W-1:0]   round_bcd,
  output logic [COUNT_W-1:0]   score_bcd,
  output logic                 busy,
  output logic                 play,
  output logic                 correct,
  output logic                 wrong,
  output logic                 timeout,
  output logic                 done
);

  localparam logic [COUNT_W-1:0] ROUNDS_BCD = to_bcd2(ROUNDS);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYC - 1);

  state_t               state_q, state_d;
  logic [OPERAND_W-1:0] op_a_q, op_a_d;
  logic [OPERAND_W-1:0] op_b_q, op_b_d;
  logic [COUNT_W-1:0]   round_q, round_d;
  logic [COUNT_W-1:0]   score_q, score_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 correct_q, correct_d;
  logic                 wrong_q, wrong_d;
  logic                 timeout_q, timeout_d;

  logic [ANSWER_W-1:0]  exp_sum;
  logic                 answer_match;

  // Expected answer is always derived from the registered operands.
  bcd_add4 u_exp_add (
    .a   (op_a_q),
    .b   (op_b_q),
    .sum (exp_sum)
  );

  assign answer_match = (answer == exp_sum);

  // Next-state, counter, timer and verdict-pulse computation.
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    round_d   = round_q;
    score_d   = score_q;
    timer_d   = timer_q;
    correct_d = 1'b0;
    wrong_d   = 1'b0;
    timeout_d = 1'b0;

    if (abort) begin
      // Abort beats everything; counts are kept for the scoreboard.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            score_d = {COUNT_W{1'b0}};
            op_a_d  = {OPERAND_W{1'b0}};
            op_b_d  = {OPERAND_W{1'b0}};
            round_d = 8'h01;
            state_d = S_FETCH_A;
          end else begin
            state_d = state_q;
          end
        end
        S_FETCH_A: state_d = S_CAP_A;
        S_CAP_A: begin
          op_a_d  = rng_d;
          state_d = S_FETCH_B;
        end
        S_FETCH_B: state_d = S_CAP_B;
        S_CAP_B: begin
          op_b_d  = rng_d;
          timer_d = TIMER_LOAD;
          state_d = S_PLAY;
        end
        S_PLAY: begin
          // A submit on the last timer cycle still counts as an answer.
          if (submit) begin
            correct_d = answer_match;
            wrong_d   = ~answer_match;
            state_d   = S_JUDGE;
          end else if (timer_q == {TIMER_W{1'b0}}) begin
            timeout_d = 1'b1;
            state_d   = S_JUDGE;
          end else begin
            timer_d = timer_q - {{(TIMER_W-1){1'b0}}, 1'b1};
          end
        end
        S_JUDGE: begin
          if (correct_q) begin
            score_d = bcd_inc2(score_q);
          end else begin
            score_d = score_q;
          end
          if (round_q == ROUNDS_BCD) begin
            state_d = S_DONE;
          end else begin
            round_d = bcd_inc2(round_q);
            state_d = S_FETCH_A;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, operand, counter, timer and verdict registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_a_q    <= {OPERAND_W{1'b0}};
      op_b_q    <= {OPERAND_W{1'b0}};
      round_q   <= {COUNT_W{1'b0}};
      score_q   <= {COUNT_W{1'b0}};
      timer_q   <= {TIMER_W{1'b0}};
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      round_q   <= round_d;
      score_q   <= score_d;
      timer_q   <= timer_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      timeout_q <= timeout_d;
    end
  end

  // Flags are decoded from the state register so reset clears them at once.
  assign fetch_num = (state_q == S_FETCH_A) || (state_q == S_FETCH_B);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign play      = (state_q == S_PLAY);
  assign done      = (state_q == S_DONE);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign round_bcd = round_q;
  assign score_bcd = score_q;
  assign correct   = correct_q;
  assign wrong     = wrong_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_bcd_round_sequencer.sv
// Self-checking bench for bcd_round_sequencer.
// Two instances share all inputs: dut (ROUNDS=12) and dut3 (ROUNDS=3), both
// with TIMEOUT_CYC=8. An RNG model serves queued or random BCD digits.
module tb_bcd_round_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        submit;
  logic [19:0] answer;
  logic [15:0] rng_d = 16'h0000;

  logic        fetch_num, busy, play, correct, wrong, timeout, done;
  logic [15:0] op_a, op_b;
  logic [7:0]  round_bcd, score_bcd;

  logic        fetch_num_3, busy_3, play_3, correct_3, wrong_3, timeout_3, done_3;
  logic [15:0] op_a_3, op_b_3;
  logic [7:0]  round_bcd_3, score_bcd_3;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] rng_queue[$];

  bcd_round_sequencer #(.ROUNDS(12), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rng_d(rng_d),
    .submit(submit), .answer(answer), .fetch_num(fetch_num), .op_a(op_a),
    .op_b(op_b), .round_bcd(round_bcd), .score_bcd(score_bcd), .busy(busy),
    .play(play), .correct(correct), .wrong(wrong), .timeout(timeout), .done(done)
  );

  bcd_round_sequencer #(.ROUNDS(3), .TIMEOUT_CYC(8)) dut3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rng_d(rng_d),
    .submit(submit), .answer(answer), .fetch_num(fetch_num_3), .op_a(op_a_3),
    .op_b(op_b_3), .round_bcd(round_bcd_3), .score_bcd(score_bcd_3), .busy(busy_3),
    .play(play_3), .correct(correct_3), .wrong(wrong_3), .timeout(timeout_3), .done(done_3)
  );

  always #5 clk = ~clk;

  // ---------------- reference model helpers ----------------
  function automatic logic [15:0] rand_bcd4();
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'($urandom_range(9, 0));
    return r;
  endfunction

  function automatic int bcd_to_int(input logic [19:0] v);
    int r;
    r = 0;
    for (int i = 4; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [19:0] int_to_bcd5(input int n);
    logic [19:0] r;
    int m;
    r = 20'h00000;
    m = n;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] int_to_bcd2(input int n);
    return {4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [19:0] model_sum(input logic [15:0] a, input logic [15:0] b);
    return int_to_bcd5(bcd_to_int({4'h0, a}) + bcd_to_int({4'h0, b}));
  endfunction

  // RNG model: new digits are registered on each fetch strobe edge of dut.
  always @(posedge clk) begin
    if (fetch_num) begin
      if (rng_queue.size() > 0) rng_d <= rng_queue.pop_front();
      else                      rng_d <= rand_bcd4();
    end
  end

  // ---------------- stimulus helpers (no checks) ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Called with FETCH_A visible; returns cycles until PLAY (bounded).
  task automatic reach_play(output int n, output int nfetch, output int gap);
    int first;
    first  = -1;
    n      = 0;
    nfetch = 0;
    gap    = 0;
    for (int i = 0; i < 20; i++) begin
      if (play) break;
      if (fetch_num) begin
        if (nfetch == 0) first = i;
        else             gap   = i - first;
        nfetch++;
      end
      tick();
      n++;
    end
  endtask

  task automatic submit_ans(input logic [19:0] a);
    answer = a;
    submit = 1'b1;
    tick();
    submit = 1'b0;
  endtask

  task automatic play_round(input logic [15:0] a, input logic [15:0] b,
                            input logic [19:0] ans, output int lat,
                            output logic [2:0] verdict);
    int nf, gap;
    rng_queue.delete();
    rng_queue.push_back(a);
    rng_queue.push_back(b);
    reach_play(lat, nf, gap);
    submit_ans(ans);
    verdict = {correct, wrong, timeout};
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; submit = 1'b0; answer = 20'h0;
    tick(); tick(); tick();
    tests_run++;
    if ({busy, play, done, fetch_num, correct, wrong, timeout} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000000", {busy, play, done, fetch_num, correct, wrong, timeout});
    end
    tests_run++;
    if ({op_a, op_b} !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_ops: got %h/%h expected 0/0", op_a, op_b);
    end
    tests_run++;
    if ({round_bcd, score_bcd} !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_counts: got %h/%h expected 00/00", round_bcd, score_bcd);
    end
    rst = 1'b0;
    tick(); tick();
    tests_run++;
    if ({busy, fetch_num, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got %b expected 000", {busy, fetch_num, done});
    end
  endtask

  task automatic test_correct();
    int n, nf, gap;
    logic [19:0] exp_v;
    rng_queue.delete();
    rng_queue.push_back(16'h1234);
    rng_queue.push_back(16'h5678);
    start_game();
    reach_play(n, nf, gap);
    tests_run++;
    if (n !== 4) begin tests_failed++; $display("FAIL start_to_play: got %0d expected 4", n); end
    tests_run++;
    if (nf !== 2 || gap !== 2) begin
      tests_failed++; $display("FAIL fetch_pulses: got count %0d gap %0d expected 2/2", nf, gap);
    end
    tests_run++;
    if (op_a !== 16'h1234 || op_b !== 16'h5678) begin
      tests_failed++; $display("FAIL operands: got %h/%h expected 1234/5678", op_a, op_b);
    end
    exp_v = model_sum(16'h1234, 16'h5678);
    submit_ans(exp_v);
    tests_run++;
    if ({correct, wrong, timeout} !== 3'b100) begin
      tests_failed++; $display("FAIL correct_pulse: got %b expected 100", {correct, wrong, timeout});
    end
    tests_run++;
    if (op_a !== 16'h1234 || op_b !== 16'h5678) begin
      tests_failed++; $display("FAIL operands_judge: got %h/%h expected 1234/5678", op_a, op_b);
    end
    tick();
    tests_run++;
    if (score_bcd !== 8'h01 || round_bcd !== 8'h02) begin
      tests_failed++; $display("FAIL score_round_1: got %h/%h expected 01/02", score_bcd, round_bcd);
    end
    tests_run++;
    if ({fetch_num, correct} !== 2'b10) begin
      tests_failed++; $display("FAIL turnaround: got %b expected 10", {fetch_num, correct});
    end
  endtask

  task automatic test_carry_wrong();
    int lat;
    logic [2:0] v;
    play_round(16'h9999, 16'h9999, 20'h19997, lat, v);
    tests_run++;
    if (v !== 3'b010) begin tests_failed++; $display("FAIL carry_wrong: got %b expected 010", v); end
    tests_run++;
    if (score_bcd !== 8'h01) begin tests_failed++; $display("FAIL score_after_wrong: got %h expected 01", score_bcd); end
    play_round(16'h9999, 16'h9999, model_sum(16'h9999, 16'h9999), lat, v);
    tests_run++;
    if (v !== 3'b100) begin tests_failed++; $display("FAIL carry_correct: got %b expected 100", v); end
    tests_run++;
    if (score_bcd !== 8'h02) begin tests_failed++; $display("FAIL score_after_carry: got %h expected 02", score_bcd); end
  endtask

  task automatic test_timeout();
    int n, nf, gap, cnt;
    logic [15:0] a, b;
    do_abort();
    start_game();
    rng_queue.delete();
    rng_queue.push_back(rand_bcd4());
    rng_queue.push_back(rand_bcd4());
    reach_play(n, nf, gap);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (!play) break;
      cnt++;
      tick();
    end
    tests_run++;
    if (cnt !== 8) begin tests_failed++; $display("FAIL play_length: got %0d expected 8", cnt); end
    tests_run++;
    if ({correct, wrong, timeout} !== 3'b001) begin
      tests_failed++; $display("FAIL timeout_pulse: got %b expected 001", {correct, wrong, timeout});
    end
    tick();
    tests_run++;
    if (score_bcd !== 8'h00 || round_bcd !== 8'h02) begin
      tests_failed++; $display("FAIL after_timeout: got %h/%h expected 00/02", score_bcd, round_bcd);
    end
    a = rand_bcd4();
    b = rand_bcd4();
    rng_queue.delete();
    rng_queue.push_back(a);
    rng_queue.push_back(b);
    reach_play(n, nf, gap);
    for (int i = 0; i < 7; i++) tick();
    tests_run++;
    if (play !== 1'b1) begin tests_failed++; $display("FAIL play_8th_cycle: got %b expected 1", play); end
    submit_ans(model_sum(a, b));
    tests_run++;
    if ({correct, wrong, timeout} !== 3'b100) begin
      tests_failed++; $display("FAIL late_submit: got %b expected 100", {correct, wrong, timeout});
    end
  endtask

  task automatic test_abort();
    int n, nf, gap, lat;
    logic [2:0] v;
    logic [15:0] a, b;
    do_abort();
    start_game();
    a = rand_bcd4();
    b = rand_bcd4();
    play_round(a, b, model_sum(a, b), lat, v);
    rng_queue.delete();
    reach_play(n, nf, gap);
    tick(); tick();
    abort = 1'b1;
    submit = 1'b1;
    answer = 20'h00000;
    tick();
    abort = 1'b0;
    submit = 1'b0;
    tests_run++;
    if ({busy, play, fetch_num, correct, wrong, timeout} !== 6'b0) begin
      tests_failed++; $display("FAIL abort_idle: got %b expected 000000", {busy, play, fetch_num, correct, wrong, timeout});
    end
    tests_run++;
    if (score_bcd !== 8'h01 || round_bcd !== 8'h02) begin
      tests_failed++; $display("FAIL abort_hold: got %h/%h expected 01/02", score_bcd, round_bcd);
    end
    submit_ans(20'h00000);
    tests_run++;
    if ({busy, correct, wrong, timeout} !== 4'b0) begin
      tests_failed++; $display("FAIL submit_in_idle: got %b expected 0000", {busy, correct, wrong, timeout});
    end
  endtask

  task automatic test_full_game();
    int n, nf, gap;
    logic [15:0] a, b;
    do_abort();
    start_game();
    for (int r = 1; r <= 3; r++) begin
      a = rand_bcd4();
      b = rand_bcd4();
      rng_queue.delete();
      rng_queue.push_back(a);
      rng_queue.push_back(b);
      reach_play(n, nf, gap);
      if (r == 2) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (play_3 !== 1'b1 || round_bcd_3 !== 8'h02 || score_bcd_3 !== 8'h01) begin
          tests_failed++;
          $display("FAIL start_while_busy: got play %b round %h score %h expected 1/02/01", play_3, round_bcd_3, score_bcd_3);
        end
      end
      submit_ans(model_sum(a, b));
      tests_run++;
      if ({correct_3, wrong_3, timeout_3} !== 3'b100) begin
        tests_failed++; $display("FAIL game_round_%0d: got %b expected 100", r, {correct_3, wrong_3, timeout_3});
      end
      tick();
    end
    tests_run++;
    if ({done_3, busy_3} !== 2'b10 || round_bcd_3 !== 8'h03 || score_bcd_3 !== 8'h03) begin
      tests_failed++;
      $display("FAIL game_done: got done %b busy %b round %h score %h expected 1/0/03/03", done_3, busy_3, round_bcd_3, score_bcd_3);
    end
    start_game();
    tests_run++;
    if ({done_3, busy_3} !== 2'b01 || round_bcd_3 !== 8'h01 || score_bcd_3 !== 8'h00) begin
      tests_failed++;
      $display("FAIL restart_from_done: got done %b busy %b round %h score %h expected 0/1/01/00", done_3, busy_3, round_bcd_3, score_bcd_3);
    end
    tests_run++;
    if (round_bcd !== 8'h04 || score_bcd !== 8'h03) begin
      tests_failed++; $display("FAIL busy_start_ignored: got %h/%h expected 04/03", round_bcd, score_bcd);
    end
  endtask

  task automatic test_random();
    int lat, score_m;
    logic [2:0] v, v_exp;
    logic [15:0] a, b;
    logic [19:0] s, ans;
    do_abort();
    start_game();
    score_m = 0;
    for (int r = 1; r <= 12; r++) begin
      a = rand_bcd4();
      b = rand_bcd4();
      s = model_sum(a, b);
      if ($urandom_range(1, 0) == 1) begin
        ans = s;
        v_exp = 3'b100;
        score_m++;
      end else begin
        ans = int_to_bcd5((bcd_to_int(s) + 1 + int'($urandom_range(500, 0))) % 20000);
        v_exp = 3'b010;
      end
      play_round(a, b, ans, lat, v);
      tests_run++;
      if (v !== v_exp) begin
        tests_failed++; $display("FAIL rand_verdict r%0d: %h+%h ans %h got %b expected %b", r, a, b, ans, v, v_exp);
      end
      tests_run++;
      if (score_bcd !== int_to_bcd2(score_m)) begin
        tests_failed++; $display("FAIL rand_score r%0d: got %h expected %h", r, score_bcd, int_to_bcd2(score_m));
      end
    end
    tests_run++;
    if (done !== 1'b1 || round_bcd !== 8'h12) begin
      tests_failed++; $display("FAIL rand_done: got done %b round %h expected 1/12", done, round_bcd);
    end
  endtask

  task automatic test_score_carry();
    int lat;
    logic [2:0] v;
    logic [15:0] a, b;
    start_game();
    for (int r = 1; r <= 12; r++) begin
      a = rand_bcd4();
      b = rand_bcd4();
      play_round(a, b, model_sum(a, b), lat, v);
      tests_run++;
      if (score_bcd !== int_to_bcd2(r) || v !== 3'b100) begin
        tests_failed++; $display("FAIL score_carry r%0d: got score %h verdict %b expected %h/100", r, score_bcd, v, int_to_bcd2(r));
      end
    end
    tests_run++;
    if (done !== 1'b1 || round_bcd !== 8'h12 || score_bcd !== 8'h12) begin
      tests_failed++; $display("FAIL carry_done: got done %b round %h score %h expected 1/12/12", done, round_bcd, score_bcd);
    end
  endtask

  task automatic test_async_reset();
    do_abort();
    rng_queue.delete();
    rng_queue.push_back(16'h4321);
    rng_queue.push_back(16'h1111);
    start_game();
    tick();
    tick();
    tests_run++;
    if (fetch_num !== 1'b1 || op_a !== 16'h4321) begin
      tests_failed++; $display("FAIL fetch_b_state: got fetch %b op_a %h expected 1/4321", fetch_num, op_a);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({fetch_num, busy, play, done} !== 4'b0 || op_a !== 16'h0 || round_bcd !== 8'h0 || score_bcd !== 8'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got fetch %b busy %b op_a %h round %h score %h expected all 0", fetch_num, busy, op_a, round_bcd, score_bcd);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_after_async: got busy %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_carry_wrong();
    test_timeout();
    test_abort();
    test_full_game();
    test_random();
    test_score_carry();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
